axi_wr_arb_ctrl: RTL and testbench
==================================

AXI_WR_ARB_CTRL -- requirements
Module: axi_wr_arb_ctrl

Interface
REQ-001 Parameter NUM_MASTERS, default 4, is the number of requesting masters (M1..M4 map to index 0..3).
REQ-002 Parameter TIMEOUT_CYCLES, default 256, is the write-response watchdog limit in cycles; legal range is 2..256.
REQ-003 ACLK, input, 1 bit: the single clock; every flop is on the rising edge.
REQ-004 ARESET, input, 1 bit: reset, synchronous to ACLK and active-high.
REQ-005 req, input, NUM_MASTERS bits: per-master AWVALID, already address-decoded to this slave port.
REQ-006 aw_hs, input, 1 bit: slave-side AWVALID&&AWREADY of the muxed AW channel.
REQ-007 w_last_hs, input, 1 bit: slave-side WVALID&&WREADY&&WLAST of the muxed W channel.
REQ-008 b_hs, input, 1 bit: BVALID&&BREADY on the response path back to the granted master.
REQ-009 grant, output, NUM_MASTERS bits: one-hot owner of the slave port, or all zero.
REQ-010 grant_idx, output, clog2(NUM_MASTERS) bits: binary index of the granted master, used as the mux select.
REQ-011 aw_sel_en, w_sel_en, b_sel_en, outputs, 1 bit each: enable the AW, W and B mux paths respectively.
REQ-012 busy, output, 1 bit: the FSM is not in IDLE.
REQ-013 timeout_err, output, 1 bit: one-cycle pulse raised when the write-response watchdog expires.

Function
REQ-014 The FSM has four states: IDLE, AW_PH, W_PH and B_PH; all outputs are registered or decoded from the state register.
REQ-015 IDLE: when req is nonzero, the FSM captures a round-robin winner and moves to AW_PH; grant is visible on the next cycle (1-cycle latency).
REQ-016 Round-robin order searches upward, with wrap-around, from the index one above last_idx; the winner is the first set req bit.
REQ-017 last_idx updates to the winner only when the transaction completes (REQ-020 or REQ-021).
REQ-018 AW_PH asserts aw_sel_en and moves to W_PH on aw_hs. W_PH asserts w_sel_en and moves to B_PH on w_last_hs.
REQ-019 w_last_hs is ignored outside W_PH, and aw_hs is ignored outside AW_PH.
REQ-020 B_PH asserts b_sel_en and returns to IDLE on b_hs.
REQ-021 Watchdog: an 8-bit counter clears on entry to B_PH and increments each B_PH cycle.
REQ-022 When the counter reaches TIMEOUT_CYCLES-1 without b_hs, the block pulses timeout_err and returns to IDLE.
REQ-023 If b_hs and watchdog expiry coincide, b_hs wins and no error is raised.
REQ-024 grant and grant_idx stay stable from AW_PH through B_PH, even if the granted req deasserts; there is no preemption.
REQ-025 In IDLE: grant is zero, grant_idx is zero, all *_sel_en are 0 and busy is 0.
REQ-026 IDLE re-arbitrates in the same cycle it is entered, so back-to-back transactions have one IDLE cycle between them.
REQ-027 When the FSM leaves B_PH with a single requester still asserted, that same master is granted again.

Reset
REQ-028 While ARESET=1 at a rising ACLK edge: state=IDLE, last_idx=NUM_MASTERS-1 (so M1 has first priority), counter=0, and every output is 0.
REQ-029 Asserting ARESET mid-transaction in any state aborts that transaction within one cycle, with no timeout_err.

Structure
REQ-030 The state enum, the NUM_MASTERS default and the TIMEOUT_CYCLES default live in axi_common_types_pkg.
REQ-031 The round-robin winner search is one combinational sub-module, rr_prio_sel, with inputs req and last_idx and outputs a one-hot winner and its index.
REQ-032 The FSM, the watchdog and the last_idx register stay in axi_wr_arb_ctrl.

Verification
REQ-033 After reset, req=4'b1111: grant=0001 one cycle later; after the full AW/W/B handshakes the next grants are 0010, then 0100, then 1000.
REQ-034 req=0100 only: grant=0100 and aw_sel_en=1; aw_hs gives w_sel_en=1; w_last_hs gives b_sel_en=1; b_hs gives busy=0 the next cycle.
REQ-035 Granted, aw_hs done, no b_hs for 256 cycles in B_PH: a single 1-cycle timeout_err pulse, then IDLE.
REQ-036 b_hs on watchdog cycle 255: return to IDLE with timeout_err=0.
REQ-037 ARESET=1 during W_PH: all outputs 0 on the next cycle; after release with req=1000, grant=0001 is not issued and grant=1000 is.
REQ-038 w_last_hs pulsed during AW_PH: ignored; the FSM still waits for aw_hs, then for w_last_hs in W_PH.

Source files
------------

// File: rtl/axi_common_types_pkg.sv
// Shared types and defaults for the AXI write-path arbiter.
package axi_common_types_pkg;

    localparam int DEF_NUM_MASTERS    = 4;
    localparam int DEF_TIMEOUT_CYCLES = 256;
    localparam int WD_CNT_W           = 8;

    // One state per AXI write channel phase, plus IDLE for arbitration.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AW_PH = 2'd1,
        W_PH  = 2'd2,
        B_PH  = 2'd3
    } wr_state_e;

endpackage

// File: rtl/rr_prio_sel.sv
// Round-robin winner search: first set req bit above last_idx, with wrap-around.
module rr_prio_sel #(
    parameter int NUM_MASTERS = axi_common_types_pkg::DEF_NUM_MASTERS,
    parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last_idx,
    output logic [NUM_MASTERS-1:0] winner,
    output logic [IDX_W-1:0]       winner_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan the masters starting one above the previous owner; first hit wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = IDX_W'((int'(last_idx) + i) % NUM_MASTERS);
            if (!found && req[cand]) begin
                found      = 1'b1;
                winner_idx = cand;
            end
        end
        winner[winner_idx] = found;
    end

endmodule

// File: rtl/axi_wr_arb_ctrl.sv
// Single-slave AXI write arbiter: round-robin grant held through the AW, W and B
// phases, with a watchdog on the write response.
module axi_wr_arb_ctrl
    import axi_common_types_pkg::*;
#(
    parameter  int NUM_MASTERS    = DEF_NUM_MASTERS,
    parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IDX_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   aw_hs,
    input  logic                   w_last_hs,
    input  logic                   b_hs,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   aw_sel_en,
    output logic                   w_sel_en,
    output logic                   b_sel_en,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam logic [WD_CNT_W-1:0] WD_LIMIT  = WD_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]    LAST_INIT = IDX_W'(NUM_MASTERS - 1);

    wr_state_e                state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q;
    logic [IDX_W-1:0]         grant_idx_q;
    logic [IDX_W-1:0]         last_idx_q;
    logic [WD_CNT_W-1:0]      wd_cnt_q;
    logic                     timeout_q;

    logic [NUM_MASTERS-1:0]   rr_winner;
    logic [IDX_W-1:0]         rr_winner_idx;
    logic                     load_grant;
    logic                     complete;
    logic                     expire;

    rr_prio_sel #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_rr_prio_sel (
        .req        (req),
        .last_idx   (last_idx_q),
        .winner     (rr_winner),
        .winner_idx (rr_winner_idx)
    );

    // Next-state logic; b_hs is tested before the watchdog so it wins a tie.
    always_comb begin
        state_d    = state_q;
        load_grant = 1'b0;
        complete   = 1'b0;
        expire     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = AW_PH;
                    load_grant = 1'b1;
                end
            end
            AW_PH: if (aw_hs)     state_d = W_PH;
            W_PH:  if (w_last_hs) state_d = B_PH;
            B_PH: begin
                if (b_hs) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                end else if (wd_cnt_q == WD_LIMIT) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                    expire   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and the registered timeout pulse.
    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (ARESET) begin
            state_q   <= IDLE;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= expire;
        end
    end

    // Grant is captured on arbitration, held with no preemption, and cleared on completion.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_idx_q  <= LAST_INIT;
        end else if (load_grant) begin
            grant_q     <= rr_winner;
            grant_idx_q <= rr_winner_idx;
        end else if (complete) begin
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_idx_q  <= grant_idx_q;
        end
    end

    // Watchdog counts B_PH cycles; it sits at zero everywhere else, so entry always starts at 0.
    always_ff @(posedge ACLK) begin
        if (ARESET || state_q != B_PH) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign aw_sel_en   = (state_q == AW_PH);
    assign w_sel_en    = (state_q == W_PH);
    assign b_sel_en    = (state_q == B_PH);
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_axi_wr_arb_ctrl.sv
// Self-checking bench for axi_wr_arb_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_axi_wr_arb_ctrl;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int T  = 256;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [N-1:0]  req;
    logic          aw_hs, w_last_hs, b_hs;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          aw_sel_en, w_sel_en, b_sel_en, busy, timeout_err;

    int checks = 0;
    int errors = 0;

    axi_wr_arb_ctrl #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .req         (req),
        .aw_hs       (aw_hs),
        .w_last_hs   (w_last_hs),
        .b_hs        (b_hs),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .aw_sel_en   (aw_sel_en),
        .w_sel_en    (w_sel_en),
        .b_sel_en    (b_sel_en),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 ACLK = ~ACLK;

    // ---------------- behavioural model ----------------
    // owner: granted master or -1; stage: handshakes completed so far
    // (0 waiting AW, 1 waiting W last, 2 waiting B); bcnt: cycles already spent waiting for B.
    int m_owner = -1, m_stage = 0, m_last = N - 1, m_bcnt = 0;
    bit m_to = 0, m_valid = 0;

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int c = (last + k) % N;
            if (r[c[1:0]]) return c;
        end
        return -1;
    endfunction

    initial forever begin
        @(posedge ACLK);
        if (ARESET) begin
            m_owner = -1; m_stage = 0; m_last = N - 1; m_bcnt = 0; m_to = 0; m_valid = 1;
        end else begin
            m_to = 0;
            if (m_owner < 0) begin
                if (req != 0) begin
                    m_owner = rr_pick(req, m_last);
                    m_stage = 0;
                end
            end else if (m_stage == 0) begin
                if (aw_hs) m_stage = 1;
            end else if (m_stage == 1) begin
                if (w_last_hs) begin m_stage = 2; m_bcnt = 0; end
            end else begin
                if (b_hs) begin
                    m_last = m_owner; m_owner = -1;
                end else if (m_bcnt == T - 1) begin
                    m_last = m_owner; m_owner = -1; m_to = 1;
                end else begin
                    m_bcnt++;
                end
            end
        end
    end

    function automatic logic [10:0] model_vec();
        logic [N-1:0]  g;
        logic [IW-1:0] gi;
        bit            own;
        own = (m_owner >= 0);
        g   = own ? N'(1 << m_owner) : '0;
        gi  = own ? IW'(m_owner) : '0;
        return {g, gi, own && m_stage == 0, own && m_stage == 1, own && m_stage == 2, own, m_to};
    endfunction

    wire [10:0] dut_vec = {grant, grant_idx, aw_sel_en, w_sel_en, b_sel_en, busy, timeout_err};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle once reset has been seen, DUT outputs must equal the model.
    initial forever begin
        @(negedge ACLK);
        if (m_valid) check("model_cycle", 32'(dut_vec), 32'(model_vec()));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic pulse_aw();  aw_hs = 1'b1;     tick(); aw_hs = 1'b0;     endtask
    task automatic pulse_w();   w_last_hs = 1'b1; tick(); w_last_hs = 1'b0; endtask
    task automatic pulse_b();   b_hs = 1'b1;      tick(); b_hs = 1'b0;      endtask

    task automatic complete_txn();
        pulse_aw();
        pulse_w();
        pulse_b();
    endtask

    initial begin
        ARESET = 1'b1; req = '0; aw_hs = 1'b0; w_last_hs = 1'b0; b_hs = 1'b0;
        tick(); tick();
        ARESET = 1'b0;
        check("reset_outputs", 32'(dut_vec), 32'd0);

        // Full rotation with all masters requesting.
        req = 4'b1111;
        tick();
        check("rr_first_grant", 32'(grant), 32'h1);
        check("rr_first_aw_en", 32'(aw_sel_en), 32'd1);
        check("rr_first_idx", 32'(grant_idx), 32'd0);
        complete_txn();
        tick();
        check("rr_grant_2", 32'(grant), 32'h2);
        complete_txn();
        tick();
        check("rr_grant_3", 32'(grant), 32'h4);
        complete_txn();
        tick();
        check("rr_grant_4", 32'(grant), 32'h8);
        check("rr_idx_4", 32'(grant_idx), 32'd3);
        req = '0;
        complete_txn();
        check("rr_idle_after", 32'(busy), 32'd0);

        // Single requester walks through each phase.
        req = 4'b0100;
        tick();
        check("single_grant", 32'(grant), 32'h4);
        check("single_aw_en", 32'(aw_sel_en), 32'd1);
        req = '0;
        pulse_aw();
        check("single_w_en", 32'(w_sel_en), 32'd1);
        check("single_grant_held", 32'(grant), 32'h4);
        pulse_w();
        check("single_b_en", 32'(b_sel_en), 32'd1);
        pulse_b();
        check("single_busy_clear", 32'(busy), 32'd0);

        // w_last_hs during AW phase is ignored.
        req = 4'b0001;
        tick();
        req = '0;
        pulse_w();
        check("early_wlast_aw_en", 32'(aw_sel_en), 32'd1);
        check("early_wlast_w_en", 32'(w_sel_en), 32'd0);
        pulse_aw();
        check("early_wlast_then_w", 32'(w_sel_en), 32'd1);
        pulse_w();
        check("early_wlast_then_b", 32'(b_sel_en), 32'd1);
        pulse_b();

        // Watchdog expiry: 256 B_PH cycles without b_hs.
        req = 4'b0010;
        tick();
        req = '0;
        pulse_aw();
        pulse_w();
        repeat (T - 1) tick();
        check("wd_last_b_cycle", 32'(b_sel_en), 32'd1);
        check("wd_no_early_err", 32'(timeout_err), 32'd0);
        tick();
        check("wd_err_pulse", 32'(timeout_err), 32'd1);
        check("wd_back_idle", 32'(busy), 32'd0);
        check("wd_grant_clear", 32'(grant), 32'd0);
        tick();
        check("wd_err_one_cycle", 32'(timeout_err), 32'd0);

        // b_hs on the final watchdog cycle wins over expiry.
        req = 4'b0100;
        tick();
        req = '0;
        pulse_aw();
        pulse_w();
        repeat (T - 1) tick();
        pulse_b();
        check("wd_tie_idle", 32'(busy), 32'd0);
        check("wd_tie_no_err", 32'(timeout_err), 32'd0);
        tick();
        check("wd_tie_no_err_late", 32'(timeout_err), 32'd0);

        // Reset during W_PH aborts; priority restarts at M1 but only M4 requests.
        req = 4'b0001;
        tick();
        req = '0;
        pulse_aw();
        check("rst_mid_w_en", 32'(w_sel_en), 32'd1);
        ARESET = 1'b1;
        tick();
        check("rst_mid_outputs", 32'(dut_vec), 32'd0);
        ARESET = 1'b0;
        req = 4'b1000;
        tick();
        check("rst_mid_regrant", 32'(grant), 32'h8);
        req = '0;
        complete_txn();

        // Randomized traffic; one block withholds b_hs to exercise the watchdog.
        for (int blk = 0; blk < 6; blk++) begin
            for (int cyc = 0; cyc < 400; cyc++) begin
                ARESET    = ($urandom_range(0, 299) == 0);
                req       = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
                aw_hs     = ($urandom_range(0, 2) == 0);
                w_last_hs = ($urandom_range(0, 2) == 0);
                b_hs      = (blk == 3) ? 1'b0 : ($urandom_range(0, 3) == 0);
                tick();
            end
        end
        ARESET = 1'b0; req = '0; aw_hs = 1'b0; w_last_hs = 1'b0; b_hs = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
